qc_ldpc_stream_encoder: RTL and testbench
=========================================

# qc_ldpc_stream_encoder

Block-serial, runtime-configurable QC-LDPC encoder. Accepts one Z-bit information circulant per cycle over a valid/ready stream and passes it straight through to the codeword output. It keeps one rotate-XOR accumulator per parity row and then drains the parity circulants. It replaces the fixed-table combinational encoder in the TX datapath: the shift table is loadable at run time and the information length is selectable per frame.

## Interface
- `Z`, 54: circulant size in bits.
- `NUM_INFO_BLKS` (K), 20: maximum information blocks per frame.
- `NUM_PARITY_BLKS` (P), 4: parity blocks per frame.
- `SW`, `$clog2(Z)`: width of a shift value.
- `RW` / `CWD` / `NW`: `max(1,$clog2(P))` / `max(1,$clog2(K))` / `$clog2(K+1)`.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: shift-table write strobe.
- `cfg_row` in RW: parity row of the write.
- `cfg_col` in CWD: info column of the write.
- `cfg_en` in 1: 1 means a circulant is present; 0 means a zero block (the old table's −1).
- `cfg_shift` in SW: cyclic left rotation amount.
- `cfg_err` out 1: one-cycle pulse when a write is rejected.
- `num_info` in NW: info blocks in the next frame; sampled on the frame's first accepted block.
- `in_valid` in 1, `in_ready` out 1, `in_data` in Z: info block stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out Z: codeword block stream.
- `out_last` out 1: marks the final parity block of a frame.
- `out_is_parity` out 1: the current output beat is a parity block.
- `busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
- **Shift table:** P×K entries of {en, shift}, held in registers. Reset clears every entry to {0,0}.
- **Table writes:** accepted only in IDLE and only when no input block is accepted in the same cycle. The write takes effect the next cycle.
  - A write is rejected if it arrives outside that window, or if `cfg_row`≥P, `cfg_col`≥K or `cfg_shift`≥Z.
  - A rejected write leaves the table unchanged and pulses `cfg_err` the next cycle.
- **Rotation:** `rotl(v,s)` moves bit i to bit (i+s) mod Z; s=0 returns v unchanged.
- **Accumulators:** `acc[0..P-1]`, Z bits each.
  - On each accepted block in column c: `acc[p] ^= rotl(in_data, shift[p][c])` for every row with en=1.
  - The accumulators are cleared on reset and in the cycle the last parity block is loaded into the output register.
- **Frame length:** `num_info` is latched as Kf on the first accepted block. A value of 0 or a value >K clamps to K.
- **State machine:**
  - IDLE: col=0. On accept, go to DRAIN if Kf=1, otherwise go to ACCUM with col=1.
  - ACCUM: each accept increments col. The accept with col=Kf−1 moves to DRAIN.
  - DRAIN: loads `acc[p]` for p=0..P−1 into the output register, one per free output slot. Loading p=P−1 sets `out_last` and returns to IDLE.
- **Input readiness:** `in_ready` = (state∈{IDLE,ACCUM}) && (!out_valid || out_ready) && !rst.
- **Info pass-through:** each accepted info block is loaded into the output register with `out_is_parity`=0 and `out_last`=0.
- **Output order per frame:** info 0..Kf−1, then parity 0..P−1.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_is_parity`=0, `cfg_err`=0, `busy`=0, state=IDLE, col=0.
- **Reset mid-frame:** the partial frame is discarded with no `out_last`, and the shift table is cleared as well.

## Timing
- **Output register:** a single stage. It loads whenever `!out_valid || out_ready`. `out_*` signals hold stable while `out_valid && !out_ready`.
- **Info latency:** an info block accepted in cycle t appears at the output in t+1.
- **Parity latency:** with the last info block accepted in t and `out_ready`=1 throughout, parity p appears in t+2+p.
- **Throughput:** Kf+P cycles per frame. The next frame's first block can be accepted in the same cycle the last parity block is presented, so frames run back to back.
- **`in_ready`:** 0 throughout DRAIN. `busy` rises the cycle after the first accept and falls the cycle after the last parity is loaded.
- **Backpressure:** the accumulators update only on accepted beats, so a stall never changes the parity result.

## Test plan
- **Basic frame (Z=8, K=2, P=1):**
  - Write (0,0,en=1,s=1) and (0,1,en=1,s=0). Set num_info=2 and send 0x81, 0x0F.
  - Output must be 0x81, 0x0F, 0x0C, with `out_is_parity`=0,0,1 and `out_last` on 0x0C only.
- **Zero block:** same table with entry (0,1) written as en=0. Send 0x81, 0x0F; the parity block must be 0x03.
- **Backpressure:** in the basic frame, hold `out_ready`=0 for 3 cycles on each beat. Output values and order must be unchanged, `out_data` must stay stable while stalled, and `in_ready`=0 during each stall.
- **Config errors:**
  - A write while `busy`=1 must pulse `cfg_err` and leave parity unchanged.
  - A write with `cfg_shift`=8 (Z=8) must pulse `cfg_err`.
  - A write with `cfg_row`=1 must pulse `cfg_err`.
- **Variable length:** with num_info=1, send 0x81. Output must be 0x81, then 0x03 with `out_last`. Follow it immediately with a second frame of 2 blocks; that frame must start with no idle gap.
- **Reset mid-frame:** assert `rst` after the first info block. All outputs must take their reset values and the table must read back as zero blocks. A following frame sending 0x81, 0x0F must produce parity 0x00.

Source files
------------

// File: rtl/qc_ldpc_stream_encoder.sv
// qc_ldpc_stream_encoder
// Block-serial QC-LDPC encoder with a run-time loadable shift table.
// Info circulants pass straight through to a single-stage output register
// while one rotate-XOR accumulator per parity row collects the parity;
// after the last info block of a frame the accumulators are drained as
// parity circulants 0..P-1.
//
// state  | meaning
// IDLE   | waiting for the first info block of a frame (col = 0)
// ACCUM  | accepting info blocks 1..Kf-1
// DRAIN  | presenting parity circulants 0..P-1, input held off
module qc_ldpc_stream_encoder #(
  parameter int Z               = 54,
  parameter int NUM_INFO_BLKS   = 20,
  parameter int NUM_PARITY_BLKS = 4,
  parameter int SW              = $clog2(Z),
  localparam int RW  = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1,
  localparam int CWD = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1,
  localparam int NW  = $clog2(NUM_INFO_BLKS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [RW-1:0]  cfg_row,
  input  logic [CWD-1:0] cfg_col,
  input  logic           cfg_en,
  input  logic [SW-1:0]  cfg_shift,
  output logic           cfg_err,
  input  logic [NW-1:0]  num_info,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Z-1:0]   out_data,
  output logic           out_last,
  output logic           out_is_parity,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  logic [CWD-1:0] col_q;
  logic [NW-1:0]  kf_q;
  logic [RW-1:0]  prow_q;

  logic [Z-1:0]   acc_q [NUM_PARITY_BLKS];
  logic [Z-1:0]   acc_d [NUM_PARITY_BLKS];

  logic           tbl_en_q [NUM_PARITY_BLKS][NUM_INFO_BLKS];
  logic [SW-1:0]  tbl_sh_q [NUM_PARITY_BLKS][NUM_INFO_BLKS];

  logic [Z-1:0]   out_data_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic           out_is_parity_q;
  logic           cfg_err_q;

  logic           out_free;
  logic           in_fire;
  logic           cfg_ok;
  logic           last_col;
  logic           last_row;
  logic [NW-1:0]  kf_eff;

  // Cyclic left rotation: bit i moves to bit (i+s) mod Z. The table only
  // ever holds s < Z, so taking the upper half of the doubled word is exact.
  function automatic logic [Z-1:0] rotl(input logic [Z-1:0] v, input logic [SW-1:0] s);
    logic [2*Z-1:0] w;
    w = {v, v} << s;
    return w[2*Z-1:Z];
  endfunction

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_ACCUM)) && out_free && !rst;
  assign in_fire  = in_valid && in_ready;
  assign last_col = (int'(col_q) + 1) == int'(kf_q);
  assign last_row = int'(prow_q) == (NUM_PARITY_BLKS - 1);

  // Table writes land only between frames and never alongside an accepted block,
  // so a frame always encodes with one consistent table.
  assign cfg_ok = (state_q == S_IDLE) && !in_fire
                  && (int'(cfg_row) < NUM_PARITY_BLKS)
                  && (int'(cfg_col) < NUM_INFO_BLKS)
                  && (int'(cfg_shift) < Z);

  // Frame length for the block being accepted in IDLE; 0 or oversize means full length.
  always_comb begin
    kf_eff = num_info;
    if (num_info == '0 || int'(num_info) > NUM_INFO_BLKS) begin
      kf_eff = NW'(NUM_INFO_BLKS);
    end
  end

  // Accumulator update for the current column, used only on an accepted block.
  always_comb begin
    for (int p = 0; p < NUM_PARITY_BLKS; p++) begin
      acc_d[p] = acc_q[p];
      if (tbl_en_q[p][col_q]) begin
        acc_d[p] = acc_q[p] ^ rotl(in_data, tbl_sh_q[p][col_q]);
      end
    end
  end

  // Frame FSM, shift table, accumulators and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      col_q           <= '0;
      kf_q            <= '0;
      prow_q          <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      out_is_parity_q <= 1'b0;
      cfg_err_q       <= 1'b0;
      for (int p = 0; p < NUM_PARITY_BLKS; p++) begin
        acc_q[p] <= '0;
        for (int c = 0; c < NUM_INFO_BLKS; c++) begin
          tbl_en_q[p][c] <= 1'b0;
          tbl_sh_q[p][c] <= '0;
        end
      end
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        tbl_en_q[cfg_row][cfg_col] <= cfg_en;
        tbl_sh_q[cfg_row][cfg_col] <= cfg_shift;
      end

      // Output slot drains by default; a load below takes precedence.
      if (out_free) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (in_fire) begin
            out_valid_q     <= 1'b1;
            out_data_q      <= in_data;
            out_last_q      <= 1'b0;
            out_is_parity_q <= 1'b0;
            for (int p = 0; p < NUM_PARITY_BLKS; p++) begin
              acc_q[p] <= acc_d[p];
            end
            if (state_q == S_IDLE) begin
              kf_q <= kf_eff;
              if (kf_eff == NW'(1)) begin
                state_q <= S_DRAIN;
              end else begin
                state_q <= S_ACCUM;
                col_q   <= CWD'(1);
              end
            end else if (last_col) begin
              state_q <= S_DRAIN;
              col_q   <= '0;
            end else begin
              col_q <= col_q + CWD'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_free) begin
            out_valid_q     <= 1'b1;
            out_data_q      <= acc_q[prow_q];
            out_is_parity_q <= 1'b1;
            out_last_q      <= last_row;
            if (last_row) begin
              state_q <= S_IDLE;
              prow_q  <= '0;
              for (int p = 0; p < NUM_PARITY_BLKS; p++) begin
                acc_q[p] <= '0;
              end
            end else begin
              prow_q <= prow_q + RW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_is_parity = out_is_parity_q;
  assign cfg_err       = cfg_err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_qc_ldpc_stream_encoder.sv
// Testbench for qc_ldpc_stream_encoder (Z=8, K=2, P=1).
// Output beats are captured at the falling edge; expected beats come from
// literal values or from a bit-level rotate/XOR reference model.
`timescale 1ns/1ps
module tb_qc_ldpc_stream_encoder;
  localparam int Z  = 8;
  localparam int K  = 2;
  localparam int P  = 1;
  localparam int SW = 4;

  typedef struct {
    logic [Z-1:0] d;
    logic         par;
    logic         last;
    int           cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [0:0]    cfg_row = '0;
  logic [0:0]    cfg_col = '0;
  logic          cfg_en = 1'b0;
  logic [SW-1:0] cfg_shift = '0;
  logic          cfg_err;
  logic [1:0]    num_info = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [Z-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [Z-1:0]  out_data;
  logic          out_last;
  logic          out_is_parity;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;
  int stall_obs = 0;
  bit chk_stall = 1'b0;
  bit prev_stall = 1'b0;
  logic [Z+1:0] prev_out = '0;
  beat_t cap[$];

  logic m_en [P][K];
  int   m_sh [P][K];

  qc_ldpc_stream_encoder #(
    .Z(Z), .NUM_INFO_BLKS(K), .NUM_PARITY_BLKS(P), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_en(cfg_en),
    .cfg_shift(cfg_shift), .cfg_err(cfg_err),
    .num_info(num_info),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_is_parity(out_is_parity), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [Z-1:0] rot_m(input logic [Z-1:0] v, input int s);
    logic [Z-1:0] r;
    r = '0;
    for (int i = 0; i < Z; i++) r[(i + s) % Z] = v[i];
    return r;
  endfunction

  function automatic int clamp_m(input int ni);
    return (ni == 0 || ni > K) ? K : ni;
  endfunction

  function automatic logic [Z-1:0] parity_m(input int p, input logic [Z-1:0] blk[$]);
    logic [Z-1:0] a;
    a = '0;
    for (int c = 0; c < blk.size(); c++)
      if (m_en[p][c]) a ^= rot_m(blk[c], m_sh[p][c]);
    return a;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < P; p++)
      for (int c = 0; c < K; c++) begin
        m_en[p][c] = 1'b0;
        m_sh[p][c] = 0;
      end
  endtask

  // ---------------- output monitor / ready driver ----------------
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (!rst && out_valid && out_ready) begin
      b.d = out_data; b.par = out_is_parity; b.last = out_last; b.cyc = cyc;
      cap.push_back(b);
    end
    if (chk_stall && prev_stall) begin
      checks++;
      if ({out_last, out_is_parity, out_data} !== prev_out) begin
        errors++;
        $display("FAIL stall_hold got %h want %h", {out_last, out_is_parity, out_data}, prev_out);
      end
    end
    if (chk_stall && out_valid && !out_ready) begin
      stall_obs++;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready got %b want 0", in_ready);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_last, out_is_parity, out_data};
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        if (!out_valid) begin
          out_ready = 1'b0; stall_cnt = 0;
        end else if (stall_cnt < 3) begin
          out_ready = 1'b0; stall_cnt++;
        end else begin
          out_ready = 1'b1; stall_cnt = 0;
        end
      end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic push_block(input logic [Z-1:0] d, input logic [1:0] ni);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; num_info = ni;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL push_timeout in_ready stuck at %b want 1", in_ready);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int n);
    int t;
    t = 0;
    while (!(cap.size() >= n && !busy && !out_valid)) begin
      @(posedge clk); #1;
      t++;
      if (t > 2000) begin
        errors++;
        $display("FAIL wait_idle_timeout beats %0d want %0d", cap.size(), n);
        break;
      end
    end
  endtask

  task automatic cfg_write(input int row, input int col, input bit en, input int sh, input bit win);
    bit exp_err;
    exp_err = !win || row >= P || col >= K || sh >= Z;
    cfg_we = 1'b1; cfg_row = row[0:0]; cfg_col = col[0:0]; cfg_en = en; cfg_shift = sh[SW-1:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_err !== exp_err) begin
      errors++;
      $display("FAIL cfg_err row=%0d col=%0d sh=%0d win=%0d got %b want %b", row, col, sh, win, cfg_err, exp_err);
    end
    if (!exp_err) begin
      m_en[row][col] = en;
      m_sh[row][col] = sh;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse got %b want 0", cfg_err);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_is_parity, cfg_err, busy, in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got v%b l%b p%b e%b b%b r%b want all 0",
               out_valid, out_last, out_is_parity, cfg_err, busy, in_ready);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 00", out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [Z-1:0] ed [3] = '{8'h81, 8'h0F, 8'h0C};
    logic         ep [3] = '{1'b0, 1'b0, 1'b1};
    cfg_write(0, 0, 1'b1, 1, 1'b1);
    cfg_write(0, 1, 1'b1, 0, 1'b1);
    rdy_mode = 0; cap.delete();
    push_block(8'h81, 2'd2);
    push_block(8'h0F, 2'd2);
    in_valid = 1'b0;
    wait_idle(3);
    checks++;
    if (cap.size() != 3) begin
      errors++;
      $display("FAIL basic_count got %0d want 3", cap.size());
    end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      checks++;
      if (cap[i].d !== ed[i] || cap[i].par !== ep[i] || cap[i].last !== ep[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %h/p%b/l%b want %h/p%b/l%b", i,
                 cap[i].d, cap[i].par, cap[i].last, ed[i], ep[i], ep[i]);
      end
      checks++;
      if (cap[i].cyc != cap[0].cyc + i) begin
        errors++;
        $display("FAIL basic_timing beat%0d got cycle %0d want %0d", i, cap[i].cyc, cap[0].cyc + i);
      end
    end
  endtask

  task automatic test_zero_block();
    cfg_write(0, 1, 1'b0, 0, 1'b1);
    rdy_mode = 0; cap.delete();
    push_block(8'h81, 2'd2);
    push_block(8'h0F, 2'd2);
    in_valid = 1'b0;
    wait_idle(3);
    checks++;
    if (cap.size() != 3 || cap[2].d !== 8'h03 || cap[2].last !== 1'b1 || cap[2].par !== 1'b1) begin
      errors++;
      $display("FAIL zero_block got n=%0d last=%h want n=3 parity 03", cap.size(),
               (cap.size() > 0) ? cap[cap.size()-1].d : 8'h00);
    end
  endtask

  task automatic test_backpressure();
    logic [Z-1:0] ed [3] = '{8'h81, 8'h0F, 8'h0C};
    logic         ep [3] = '{1'b0, 1'b0, 1'b1};
    cfg_write(0, 1, 1'b1, 0, 1'b1);
    cap.delete(); stall_obs = 0;
    rdy_mode = 1; chk_stall = 1'b1;
    push_block(8'h81, 2'd2);
    push_block(8'h0F, 2'd2);
    in_valid = 1'b0;
    wait_idle(3);
    chk_stall = 1'b0; rdy_mode = 0;
    @(posedge clk); #1;
    checks++;
    if (stall_obs < 9) begin
      errors++;
      $display("FAIL bp_stalls got %0d stalled cycles want at least 9", stall_obs);
    end
    checks++;
    if (cap.size() != 3) begin
      errors++;
      $display("FAIL bp_count got %0d want 3", cap.size());
    end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      checks++;
      if (cap[i].d !== ed[i] || cap[i].par !== ep[i] || cap[i].last !== ep[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %h/p%b/l%b want %h/p%b/l%b", i,
                 cap[i].d, cap[i].par, cap[i].last, ed[i], ep[i], ep[i]);
      end
    end
  endtask

  task automatic test_cfg_errors();
    cfg_write(0, 0, 1'b1, 8, 1'b1);
    cfg_write(1, 0, 1'b1, 1, 1'b1);
    rdy_mode = 0; cap.delete();
    push_block(8'h81, 2'd2);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_busy got %b want 1", busy);
    end
    cfg_write(0, 0, 1'b1, 5, 1'b0);
    push_block(8'h0F, 2'd2);
    in_valid = 1'b0;
    wait_idle(3);
    checks++;
    if (cap.size() != 3 || cap[2].d !== 8'h0C || cap[2].last !== 1'b1) begin
      errors++;
      $display("FAIL cfg_parity got n=%0d parity=%h want n=3 parity 0c", cap.size(),
               (cap.size() > 0) ? cap[cap.size()-1].d : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [Z-1:0] ed [5] = '{8'h81, 8'h03, 8'h3C, 8'hA5, 8'hDD};
    logic         ep [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rdy_mode = 0; cap.delete();
    push_block(8'h81, 2'd1);
    push_block(8'h3C, 2'd2);
    push_block(8'hA5, 2'd0);
    in_valid = 1'b0;
    wait_idle(5);
    checks++;
    if (cap.size() != 5) begin
      errors++;
      $display("FAIL b2b_count got %0d want 5", cap.size());
    end
    for (int i = 0; i < 5 && i < cap.size(); i++) begin
      checks++;
      if (cap[i].d !== ed[i] || cap[i].par !== ep[i] || cap[i].last !== ep[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h/p%b/l%b want %h/p%b/l%b", i,
                 cap[i].d, cap[i].par, cap[i].last, ed[i], ep[i], ep[i]);
      end
      checks++;
      if (cap[i].cyc != cap[0].cyc + i) begin
        errors++;
        $display("FAIL b2b_gap beat%0d got cycle %0d want %0d", i, cap[i].cyc, cap[0].cyc + i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    rdy_mode = 0;
    push_block(8'h81, 2'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_is_parity, cfg_err, busy} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got v%b l%b p%b e%b b%b d%h want all 0",
               out_valid, out_last, out_is_parity, cfg_err, busy, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    cap.delete();
    push_block(8'h81, 2'd2);
    push_block(8'h0F, 2'd2);
    in_valid = 1'b0;
    wait_idle(3);
    checks++;
    if (cap.size() != 3 || cap[0].d !== 8'h81 || cap[1].d !== 8'h0F
        || cap[2].d !== 8'h00 || cap[2].last !== 1'b1) begin
      errors++;
      $display("FAIL midrst_frame got n=%0d parity=%h want n=3 parity 00", cap.size(),
               (cap.size() > 0) ? cap[cap.size()-1].d : 8'h00);
    end
  endtask

  task automatic test_random();
    beat_t        ex[$];
    beat_t        b;
    logic [Z-1:0] blk[$];
    logic [Z-1:0] d;
    int           nf, ni, kf;
    rdy_mode = 2;
    for (int batch = 0; batch < 10; batch++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < K; c++)
          cfg_write(r, c, 1'($urandom_range(0, 1)), $urandom_range(0, 9), 1'b1);
      cap.delete(); ex.delete();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        ni = $urandom_range(0, 3);
        kf = clamp_m(ni);
        blk.delete();
        for (int i = 0; i < kf; i++) begin
          d = Z'($urandom);
          blk.push_back(d);
          b.d = d; b.par = 1'b0; b.last = 1'b0; b.cyc = 0;
          ex.push_back(b);
          push_block(d, (i == 0) ? ni[1:0] : 2'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        for (int p = 0; p < P; p++) begin
          b.d = parity_m(p, blk); b.par = 1'b1; b.last = (p == P - 1); b.cyc = 0;
          ex.push_back(b);
        end
      end
      in_valid = 1'b0;
      wait_idle(ex.size());
      checks++;
      if (cap.size() != ex.size()) begin
        errors++;
        $display("FAIL rand_count batch%0d got %0d want %0d", batch, cap.size(), ex.size());
      end
      for (int i = 0; i < ex.size() && i < cap.size(); i++) begin
        checks++;
        if (cap[i].d !== ex[i].d || cap[i].par !== ex[i].par || cap[i].last !== ex[i].last) begin
          errors++;
          $display("FAIL rand_beat b%0d i%0d got %h/p%b/l%b want %h/p%b/l%b", batch, i,
                   cap[i].d, cap[i].par, cap[i].last, ex[i].d, ex[i].par, ex[i].last);
        end
      end
    end
    rdy_mode = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_zero_block();
    test_backpressure();
    test_cfg_errors();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
